// File: rtl/qlf_cfg_pkg.sv
// Shared types and helpers for the qlf_k4n8 configuration scan-chain controller.
package qlf_cfg_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2,
      DONE  = 2'd3
   } cfg_state_t;

   // Flat cfg_out bit position of chain c, bit i.
   function automatic int unsigned cfg_idx(input int unsigned c, input int unsigned i,
                                           input int unsigned len);
      return c * len + i;
   endfunction

endpackage

// File: rtl/qlf_cfg_shreg.sv
// One configuration chain: LENGTH-bit left shift register, serial in at bit 0,
// serial out from the MSB, full parallel view for the shadow load.
module qlf_cfg_shreg #(
   parameter int LENGTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              sin_i,
   output logic              sout_o,
   output logic [LENGTH-1:0] par_o
);

   logic [LENGTH-1:0] sreg_q, sreg_d;

   always_comb begin
      sreg_d = sreg_q;
      if (en_i) sreg_d = {sreg_q[LENGTH-2:0], sin_i};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sreg_q <= '0;
      else        sreg_q <= sreg_d;
   end

   assign sout_o = sreg_q[LENGTH-1];
   assign par_o  = sreg_q;

endmodule

// File: rtl/qlf_cfg_chain.sv
// Configuration scan-chain controller: streams CHAINS parallel chains in from a
// valid/ready source, commits each completed load atomically to a shadow register.
module qlf_cfg_chain
   import qlf_cfg_pkg::*;
#(
   parameter  int CHAINS = 4,
   parameter  int LENGTH = 16,
   localparam int CNT_W  = $clog2(LENGTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     in_valid,
   input  logic [CHAINS-1:0]        in_data,
   output logic                     in_ready,
   output logic [CHAINS-1:0]        scan_out,
   output logic [CHAINS*LENGTH-1:0] cfg_out,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LENGTH - 1);

   cfg_state_t                      state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [CHAINS*LENGTH-1:0]        cfg_q, cfg_d;
   logic                            err_q, err_d;
   logic                            shift_en;
   logic [CHAINS-1:0][LENGTH-1:0]   par;
   logic [CHAINS*LENGTH-1:0]        par_flat;

   for (genvar c = 0; c < CHAINS; c++) begin : g_chain
      qlf_cfg_shreg #(.LENGTH(LENGTH)) u_shreg (
         .clk    (clk),
         .rst_n  (rst_n),
         .en_i   (shift_en),
         .sin_i  (in_data[c]),
         .sout_o (scan_out[c]),
         .par_o  (par[c])
      );
      assign par_flat[cfg_idx(c, 0, LENGTH) +: LENGTH] = par[c];
   end

   // abort outranks a same-cycle beat, so the shift enable is gated by it.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cfg_d    = cfg_q;
      err_d    = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (in_valid) begin
               shift_en = 1'b1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) state_d = LATCH;
            end
         end
         LATCH: begin
            cfg_d   = par_flat;
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cfg_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cfg_q   <= cfg_d;
         err_q   <= err_d;
      end
   end

   assign in_ready = (state_q == SHIFT);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign error    = err_q;
   assign cfg_out  = cfg_q;

endmodule

// File: tb/tb_qlf_cfg_chain.sv
// Directed bench for qlf_cfg_chain at CHAINS=2, LENGTH=8.
module tb_qlf_cfg_chain;

   localparam int CHAINS = 2;
   localparam int LENGTH = 8;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     abort = 1'b0;
   logic                     in_valid = 1'b0;
   logic [CHAINS-1:0]        in_data = '0;
   logic                     in_ready;
   logic [CHAINS-1:0]        scan_out;
   logic [CHAINS*LENGTH-1:0] cfg_out;
   logic                     busy, done, error;

   int n_chk = 0;
   int n_err = 0;

   // Bench-side picture of what each chain currently holds.
   logic [7:0] m0 = '0, m1 = '0;

   qlf_cfg_chain #(.CHAINS(CHAINS), .LENGTH(LENGTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .scan_out (scan_out),
      .cfg_out  (cfg_out),
      .busy     (busy),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full load: start, 8 accepted beats (MSB first), then LATCH/DONE/IDLE timing.
   // stall applies the 1,0,0,1 valid pattern; noise holds start high while busy.
   task automatic load(input logic [7:0] d0, input logic [7:0] d1, input bit stall,
                       input bit noise, input logic [15:0] exp_cfg,
                       output logic [7:0] sc0, output logic [7:0] sc1);
      int k, j;
      logic v;
      logic [1:0] held;
      sc0 = '0; sc1 = '0;
      start = 1'b1;
      tick();
      start = noise;
      chk("ld_ready", in_ready, 1'b1);
      k = 0; j = 0;
      while (k < 8 && j < 40) begin
         v = stall ? ((j % 4) == 0 || (j % 4) == 3) : 1'b1;
         in_valid = v;
         in_data  = v ? {d1[7-k], d0[7-k]} : ~{d1[7-k], d0[7-k]};
         if (v) begin
            chk("ld_scan0", scan_out[0], m0[7]);
            chk("ld_scan1", scan_out[1], m1[7]);
            sc0 = {sc0[6:0], scan_out[0]};
            sc1 = {sc1[6:0], scan_out[1]};
         end
         held = scan_out;
         tick();
         if (v) begin
            m0 = {m0[6:0], d0[7-k]};
            m1 = {m1[6:0], d1[7-k]};
            k++;
            if (k < 8) chk("ld_ready_mid", in_ready, 1'b1);
         end else begin
            chk("stall_hold", scan_out, held);
            chk("stall_nodone", done, 1'b0);
         end
         j++;
      end
      in_valid = 1'b0;
      chk("ld_beats", k, 8);
      // cycle N+1: LATCH
      chk("latch_ready", in_ready, 1'b0);
      chk("latch_busy", busy, 1'b1);
      chk("latch_done", done, 1'b0);
      tick();
      // cycle N+2: DONE with new cfg
      chk("done_pulse", done, 1'b1);
      chk("done_cfg", cfg_out, exp_cfg);
      start = 1'b0;
      tick();
      // cycle N+3: IDLE
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("idle_err", error, 1'b0);
      tick();
      chk("idle_stay", busy, 1'b0);
   endtask

   initial begin
      logic [7:0] s0, s1;
      // Reset held from time 0, released mid-cycle.
      repeat (2) @(posedge clk);
      #3;
      chk("rst_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", error, 1'b0);
      chk("rst_cfg", cfg_out, 16'h0000);
      rst_n = 1'b1;
      tick();

      // Basic load.
      load(8'hA5, 8'h3C, 1'b0, 1'b0, 16'h3CA5, s0, s1);

      // Backpressure.
      load(8'hA5, 8'h3C, 1'b1, 1'b0, 16'h3CA5, s0, s1);

      // Abort together with the 4th beat.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_data  = {1'b0, 1'b1};
         tick();
         m0 = {m0[6:0], 1'b1};
         m1 = {m1[6:0], 1'b0};
      end
      in_valid = 1'b1;
      in_data  = 2'b01;
      abort    = 1'b1;
      tick();
      in_valid = 1'b0;
      abort    = 1'b0;
      chk("abort_err", error, 1'b1);
      chk("abort_busy", busy, 1'b0);
      chk("abort_ready", in_ready, 1'b0);
      chk("abort_cfg", cfg_out, 16'h3CA5);
      chk("abort_scan", scan_out, {m1[7], m0[7]});
      tick();
      chk("abort_err_1cyc", error, 1'b0);
      chk("abort_nodone", done, 1'b0);
      load(8'h11, 8'h22, 1'b0, 1'b0, 16'h2211, s0, s1);

      // Readback: chains hold A5/3C before loading FF/00.
      load(8'hA5, 8'h3C, 1'b0, 1'b0, 16'h3CA5, s0, s1);
      load(8'hFF, 8'h00, 1'b0, 1'b0, 16'h00FF, s0, s1);
      chk("rb_scan0", s0, 8'b1010_0101);
      chk("rb_scan1", s1, 8'b0011_1100);

      // Reset mid-SHIFT after 5 beats.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = 2'b11;
         tick();
      end
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ready", in_ready, 1'b0);
      chk("mid_rst_cfg", cfg_out, 16'h0000);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_scan", scan_out, 2'b00);
      m0 = '0; m1 = '0;
      tick();
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_done", done, 1'b0);
      chk("post_rst_busy", busy, 1'b0);

      // Ignored controls: start held during SHIFT/LATCH/DONE, abort in IDLE.
      load(8'h11, 8'h22, 1'b0, 1'b1, 16'h2211, s0, s1);
      abort = 1'b1;
      tick();
      chk("idle_abort_err", error, 1'b0);
      chk("idle_abort_busy", busy, 1'b0);
      tick();
      chk("idle_abort_err2", error, 1'b0);
      abort = 1'b0;
      chk("final_cfg", cfg_out, 16'h2211);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   // Watchdog: always reach the summary line.
   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
